// File: rtl/cache_pmem_arbiter.sv
// cache_pmem_arbiter: shares one physical-memory port between the I-cache
// and D-cache. One requester is granted at a time. Its command is latched at
// grant, and the completion is returned only to that requester.
// Optional build macro CACHE_ARB_ROUND_ROBIN_EN: ties alternate between the
// two caches. Without it, the D-cache always wins ties.
//
// state  | meaning
// IDLE   | no owner, arbitrate between pending requests
// BUSY_I | I-cache owns memory, strobe driven from latched command
// BUSY_D | D-cache owns memory, strobe driven from latched command
// DONE   | turnaround cycle after completion, no strobes, no resp
module cache_pmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   op_write;
    logic   rd_next;
    logic   wr_next;
    logic   grant_i;
    logic   grant_d;
    logic   i_req;
    logic   d_req;
    logic   d_wins_tie;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Read data is broadcast to both caches; only the owner's resp qualifies it.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic last_grant_d;

    // Remember the most recent winner so simultaneous requests alternate.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_d <= 1'b0;
        end else if (grant_d) begin
            last_grant_d <= 1'b1;
        end else if (grant_i) begin
            last_grant_d <= 1'b0;
        end
    end

    assign d_wins_tie = ~last_grant_d;
`else
    assign d_wins_tie = 1'b1;
`endif

    // Next state, strobe values for the next cycle, grant pulses and owner resp.
    always_comb begin
        state_next  = state;
        rd_next     = 1'b0;
        wr_next     = 1'b0;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || d_wins_tie)) begin
                    grant_d    = 1'b1;
                    state_next = BUSY_D;
                    // A D-cache asserting read and write together is served as a writeback.
                    wr_next    = d_pmem_write;
                    rd_next    = ~d_pmem_write;
                end else if (i_req) begin
                    grant_i    = 1'b1;
                    state_next = BUSY_I;
                    rd_next    = 1'b1;
                end
            end
            BUSY_I: begin
                i_pmem_resp = pmem_resp;
                if (pmem_resp) begin
                    state_next = DONE;
                end else begin
                    rd_next = ~op_write;
                    wr_next = op_write;
                end
            end
            BUSY_D: begin
                d_pmem_resp = pmem_resp;
                if (pmem_resp) begin
                    state_next = DONE;
                end else begin
                    rd_next = ~op_write;
                    wr_next = op_write;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, registered strobes and the command latched at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            op_write     <= 1'b0;
        end else begin
            state      <= state_next;
            pmem_read  <= rd_next;
            pmem_write <= wr_next;
            if (grant_d) begin
                pmem_address <= d_pmem_address;
                pmem_wdata   <= d_pmem_wdata;
                op_write     <= d_pmem_write;
            end else if (grant_i) begin
                pmem_address <= i_pmem_address;
                op_write     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Self-checking bench for cache_pmem_arbiter: directed scenarios with literal
// expectations, then randomized caches and memory checked every cycle
// against a transaction-level model of the arbiter.
module tb_cache_pmem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    cache_pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level view: who owns memory, what command it latched,
    // and how many idle cycles remain before arbitration may happen again.
    int            m_owner = 0;   // 0 none, 1 I-cache, 2 D-cache
    int            m_gap = 0;
    bit            m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_wdata = '0;
    bit            m_last_d = 1'b0;
    int            n_grant_i = 0;
    int            n_grant_d = 0;
    bit            m_ir;
    bit            m_dr;
    bit            m_take_d;

    // Model advances on the clock edge from the values presented before it.
    always @(posedge clk) begin
        if (rst) begin
            m_owner  = 0;
            m_gap    = 0;
            m_wr     = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
            m_last_d = 1'b0;
        end else if (m_owner != 0) begin
            if (pmem_resp) begin
                m_owner = 0;
                m_gap   = 1;
            end
        end else if (m_gap > 0) begin
            m_gap = m_gap - 1;
        end else begin
            m_ir     = i_pmem_read;
            m_dr     = d_pmem_read | d_pmem_write;
            m_take_d = m_dr && (!m_ir || !RR || !m_last_d);
            if (m_take_d) begin
                m_owner   = 2;
                m_wr      = d_pmem_write;
                m_addr    = d_pmem_address;
                m_wdata   = d_pmem_wdata;
                m_last_d  = 1'b1;
                n_grant_d = n_grant_d + 1;
            end else if (m_ir) begin
                m_owner   = 1;
                m_wr      = 1'b0;
                m_addr    = i_pmem_address;
                m_last_d  = 1'b0;
                n_grant_i = n_grant_i + 1;
            end
        end
    end

    bit cmp_en = 1'b0;
    bit mem_auto = 1'b0;
    bit rand_en = 1'b0;
    bit spur_en = 1'b0;
    bit ig = 1'b0;
    bit dg = 1'b0;
    int mem_cnt = 0;
    int mem_lat = 1;
    bit mem_done = 1'b0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        v = '0;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_compare();
        logic [LW-1:0] e_rd;
        logic [LW-1:0] e_wr;
        e_rd = LW'((m_owner != 0) && !m_wr);
        e_wr = LW'((m_owner != 0) && m_wr);
        chk("m_pmem_read", LW'(pmem_read), e_rd);
        chk("m_pmem_write", LW'(pmem_write), e_wr);
        chk("m_pmem_address", LW'(pmem_address), LW'(m_addr));
        if (m_owner == 2 && m_wr) chk("m_pmem_wdata", pmem_wdata, m_wdata);
        chk("m_i_resp", LW'(i_pmem_resp), LW'((m_owner == 1) && pmem_resp));
        chk("m_d_resp", LW'(d_pmem_resp), LW'((m_owner == 2) && pmem_resp));
        chk("m_i_rdata", i_pmem_rdata, pmem_rdata);
        chk("m_d_rdata", d_pmem_rdata, pmem_rdata);
    endtask

    // Memory: answers each strobed access once after a random latency,
    // and occasionally pulses a stray resp while no strobe is up.
    task automatic mem_step();
        if (pmem_read || pmem_write) begin
            if (!mem_done) begin
                mem_cnt = mem_cnt + 1;
                if (mem_cnt >= mem_lat) begin
                    pmem_resp = 1'b1;
                    mem_done  = 1'b1;
                end else begin
                    pmem_resp = 1'b0;
                end
            end else begin
                pmem_resp = 1'b0;
            end
        end else begin
            mem_cnt   = 0;
            mem_done  = 1'b0;
            mem_lat   = $urandom_range(1, 5);
            pmem_resp = spur_en && ($urandom_range(0, 5) == 0);
        end
        pmem_rdata = rand_line();
    endtask

    // Caches: hold a request until its resp, drop it the next cycle,
    // and raise new requests at random.
    task automatic req_step();
        if (i_pmem_read) begin
            if (ig) i_pmem_read = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
            i_pmem_read    = 1'b1;
            i_pmem_address = $urandom & 32'hFFFF_FFE0;
        end
        if (d_pmem_read || d_pmem_write) begin
            if (dg) begin
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 2))
                0:       d_pmem_read = 1'b1;
                1:       d_pmem_write = 1'b1;
                default: begin d_pmem_read = 1'b1; d_pmem_write = 1'b1; end
            endcase
            d_pmem_address = $urandom & 32'hFFFF_FFE0;
            d_pmem_wdata   = rand_line();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        ig = i_pmem_resp;
        dg = d_pmem_resp;
        if (cmp_en) model_compare();
        @(posedge clk);
        #1;
        if (mem_auto) mem_step();
        if (rand_en) req_step();
    endtask

    logic [7:0] got [4];
    int         n_got;
    string      exp_order;
    int         gi0;
    int         gd0;

    initial begin
        rst = 1'b1;
        i_pmem_read = 1'b0;
        i_pmem_address = '0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata = '0;
        pmem_rdata = '0;
        pmem_resp = 1'b0;
        for (int k = 0; k < 4; k++) got[k] = 8'h0;

        tick();
        cmp_en = 1'b1;
        tick();
        #1;
        chk("rst_pmem_read", LW'(pmem_read), '0);
        chk("rst_pmem_write", LW'(pmem_write), '0);
        chk("rst_pmem_address", LW'(pmem_address), '0);
        chk("rst_pmem_wdata", pmem_wdata, '0);
        chk("rst_i_resp", LW'(i_pmem_resp), '0);
        chk("rst_d_resp", LW'(d_pmem_resp), '0);
        rst = 1'b0;

        // I-cache read alone, then an immediate second read.
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_1000;
        tick(); #1;
        chk("t1_strobe_n1", LW'(pmem_read), LW'(1));
        chk("t1_no_write", LW'(pmem_write), '0);
        chk("t1_address", LW'(pmem_address), LW'(32'h0000_1000));
        tick();
        tick();
        tick();
        pmem_resp = 1'b1;
        pmem_rdata = {8{32'hA5A5_A5A5}};
        #1;
        chk("t1_i_resp", LW'(i_pmem_resp), LW'(1));
        chk("t1_i_rdata", i_pmem_rdata, {8{32'hA5A5_A5A5}});
        chk("t1_d_resp_quiet", LW'(d_pmem_resp), '0);
        chk("t1_strobe_at_resp", LW'(pmem_read), LW'(1));
        tick();
        pmem_resp = 1'b0;
        i_pmem_address = 32'h0000_1020;
        #1;
        chk("b2b_done_read", LW'(pmem_read), '0);
        chk("b2b_done_write", LW'(pmem_write), '0);
        chk("b2b_done_resp", LW'(i_pmem_resp), '0);
        tick(); #1;
        chk("b2b_idle_read", LW'(pmem_read), '0);
        tick(); #1;
        chk("b2b_second_strobe", LW'(pmem_read), LW'(1));
        chk("b2b_second_addr", LW'(pmem_address), LW'(32'h0000_1020));
        tick();
        pmem_resp = 1'b1;
        #1;
        chk("b2b_second_resp", LW'(i_pmem_resp), LW'(1));
        tick();
        pmem_resp = 1'b0;
        i_pmem_read = 1'b0;
        #1;
        chk("b2b_second_done", LW'(pmem_read), '0);
        tick();
        tick();

        // D-cache writeback alone; inputs disturbed mid-transaction.
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_2040;
        d_pmem_wdata = {8{32'h1234_5678}};
        tick(); #1;
        chk("t2_write", LW'(pmem_write), LW'(1));
        chk("t2_no_read", LW'(pmem_read), '0);
        chk("t2_address", LW'(pmem_address), LW'(32'h0000_2040));
        chk("t2_wdata", pmem_wdata, {8{32'h1234_5678}});
        d_pmem_address = 32'hDEAD_BEE0;
        d_pmem_wdata = {8{32'h0BAD_F00D}};
        d_pmem_read = 1'b1;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_3000;
        tick(); #1;
        chk("t2_hold_address", LW'(pmem_address), LW'(32'h0000_2040));
        chk("t2_hold_wdata", pmem_wdata, {8{32'h1234_5678}});
        chk("t2_hold_write", LW'(pmem_write), LW'(1));
        chk("t2_hold_no_read", LW'(pmem_read), '0);
        tick();
        pmem_resp = 1'b1;
        #1;
        chk("t2_d_resp", LW'(d_pmem_resp), LW'(1));
        chk("t2_i_resp_quiet", LW'(i_pmem_resp), '0);
        tick();
        pmem_resp = 1'b0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        i_pmem_read = 1'b0;
        #1;
        chk("t2_done_strobes", LW'({pmem_read, pmem_write}), '0);
        tick();
        tick();

        // Read and write together from the D-cache is a write.
        d_pmem_read = 1'b1;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_4000;
        d_pmem_wdata = {8{32'hCAFE_F00D}};
        tick(); #1;
        chk("t3_write_only", LW'(pmem_write), LW'(1));
        chk("t3_no_read", LW'(pmem_read), '0);
        tick();
        pmem_resp = 1'b1;
        #1;
        chk("t3_d_resp", LW'(d_pmem_resp), LW'(1));
        tick();
        pmem_resp = 1'b0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        tick();
        tick();

        // Stray memory resp while idle.
        tick();
        pmem_resp = 1'b1;
        #1;
        chk("t4_spur_i", LW'(i_pmem_resp), '0);
        chk("t4_spur_d", LW'(d_pmem_resp), '0);
        chk("t4_spur_strobes", LW'({pmem_read, pmem_write}), '0);
        tick();
        pmem_resp = 1'b0;

        // Reset in the middle of a D-cache read; the late resp is dropped.
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_5000;
        tick(); #1;
        chk("t5_busy_read", LW'(pmem_read), LW'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_pmem_read = 1'b0;
        #1;
        chk("t5_rst_strobes", LW'({pmem_read, pmem_write}), '0);
        chk("t5_rst_address", LW'(pmem_address), '0);
        tick();
        pmem_resp = 1'b1;
        #1;
        chk("t5_late_d_resp", LW'(d_pmem_resp), '0);
        chk("t5_late_i_resp", LW'(i_pmem_resp), '0);
        tick();
        pmem_resp = 1'b0;
        #1;
        chk("t5_after_late", LW'({pmem_read, pmem_write}), '0);

        // Sustained contention from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_6000;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_7000;
        mem_auto = 1'b1;
        n_got = 0;
        for (int c = 0; c < 200 && n_got < 4; c++) begin
            tick(); #1;
            if (i_pmem_resp && n_got < 4) begin got[n_got] = "I"; n_got++; end
            if (d_pmem_resp && n_got < 4) begin got[n_got] = "D"; n_got++; end
        end
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        chk("contention_count", LW'(n_got), LW'(4));
        exp_order = RR ? "DIDI" : "DDDD";
        for (int k = 0; k < 4; k++) chk("grant_order", LW'(got[k]), LW'(exp_order[k]));
        for (int c = 0; c < 10; c++) tick();

        // Randomized traffic against the model.
        gi0 = n_grant_i;
        gd0 = n_grant_d;
        spur_en = 1'b1;
        rand_en = 1'b1;
        for (int c = 0; c < 3000; c++) tick();
        rand_en = 1'b0;
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        chk("rand_i_granted", LW'(n_grant_i > gi0), LW'(1));
        chk("rand_d_granted", LW'(n_grant_d > gd0), LW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
